bin_to_bcd_seq: RTL

//  Sequential double-dabble converter: unsigned binary word -> packed BCD digits.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bin_to_bcd_seq_if.sv | 26 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and the digit-adjust rule for the bin_to_bcd_seq converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  // Double-dabble correction: a digit that would become >=10 after doubling is pre-biased by 3.
  function automatic logic [BCD_DIGIT_W-1:0] add3(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= ADD3_THRESH) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a binary producer and the bin_to_bcd_seq converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  logic                          start;
  logic [BIN_W-1:0]              bin_in;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]             blank_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, blank_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, blank_out
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 stage for one BCD digit: values 5..9 become 8..12, others pass through.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = add3(din);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock; leading-zero blanking is
// built only when BCD_BLANK_EN is defined, otherwise blank_out is tied to 0.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
)(
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if ((64'd10 ** DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d cannot hold 2**%0d-1", DIGITS, BIN_W);
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [SCR_W-1:0] scratch_q, scratch_d;
  logic [SCR_W-1:0] bcd_q;
  logic             load_out;
  logic             busy, done;

  logic [SCR_W-1:0] adj;
  logic [SCR_W-1:0] scr_nx;
  logic [BIN_W-1:0] shf_nx;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .dout (adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );
  end

  // The adjusted top digit is always <5 before shifting, so the bit dropped by the cast is 0.
  assign scr_nx = SCR_W'({adj, shift_q[BIN_W-1]});
  assign shf_nx = {shift_q[BIN_W-2:0], 1'b0};

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    load_out  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (bus.start) begin
          state_d   = SHIFT;
          shift_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        shift_d   = shf_nx;
        scratch_d = scr_nx;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          load_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      if (load_out) bcd_q <= scr_nx;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.bcd_out = bcd_q;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nx, blank_q;
  logic              hi_zero;

  // Digit k blanks only when it and every digit above it are zero; the units digit never blanks.
  always_comb begin
    blank_nx = '0;
    hi_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero     = hi_zero && (scr_nx[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
      blank_nx[k] = hi_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (load_out) begin
      blank_q <= blank_nx;
    end
  end

  assign bus.blank_out = blank_q;
`else
  assign bus.blank_out = '0;
`endif

endmodule
